bk_adder_sequencer: RTL

//  Upstream/downstream wrapper stage for the 12-bit BrentKung combinational adder.

---
 rtl/bk_adder_sequencer_pkg.sv | 28 ++
 rtl/bk_adder_sequencer_if.sv | 26 ++
 rtl/bk_adder_sequencer_pack.sv | 12 +
 rtl/bk_adder_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bk_adder_sequencer_pkg.sv
// Shared types and helpers for the BrentKung adder sequencer slice.
// Holds operand width, bus width, FSM state encoding and the operand interleave.
package bk_pkg;

  localparam int BK_WIDTH = 12;
  localparam int BK_BUS   = 2 * BK_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } bk_state_t;

  // The adder expects A and B bit-interleaved: even lanes A, odd lanes B.
  function automatic logic [BK_BUS-1:0] bk_interleave(
    input logic [BK_WIDTH-1:0] a,
    input logic [BK_WIDTH-1:0] b
  );
    logic [BK_BUS-1:0] bus;
    bus = '0;
    for (int i = 0; i < BK_WIDTH; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_adder_sequencer_if.sv
// Operand and result valid/ready handshakes of the adder sequencer.
// master = upstream producer / downstream consumer side, slave = the sequencer.
interface bk_adder_sequencer_if;
  import bk_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [BK_WIDTH-1:0] in_a;
  logic [BK_WIDTH-1:0] in_b;
  logic                in_acc;
  logic                out_valid;
  logic                out_ready;
  logic [BK_WIDTH-1:0] out_sum;
  logic                out_cout;

  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/bk_adder_sequencer_pack.sv
// Combinational packing of an operand pair into the adder's interleaved input bus.
module bk_operand_pack
  import bk_pkg::*;
(
  input  logic [BK_WIDTH-1:0] a,
  input  logic [BK_WIDTH-1:0] b,
  output logic [BK_BUS-1:0]   bus
);

  assign bus = bk_interleave(a, b);

endmodule

// File: rtl/bk_adder_sequencer.sv
// Sequencer around an external combinational BrentKung adder: drives its input bus,
// waits a settle window, captures the result and optionally accumulates it.
module bk_adder_sequencer
  import bk_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter bit ACC_SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bk_adder_sequencer_if.slave  bus,
  input  logic                 acc_clr,
  output logic [2*WIDTH-1:0]   adder_in,
  input  logic [WIDTH:0]       adder_out,
  output logic [WIDTH-1:0]     acc_q,
  output logic                 acc_ovf
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  bk_state_t          state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] adder_in_reg;
  logic               acc_op_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic               ovf_reg, ovf_next;

  logic               in_ready;
  logic               accept;
  logic               retire;
  logic               acc_write;
  logic               capture;
  logic [WIDTH-1:0]   acc_wdata;
  logic [WIDTH-1:0]   b_eff;
  logic [2*WIDTH-1:0] packed_bus;

  assign in_ready  = rst_n & ((state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready));
  assign accept    = bus.in_valid & in_ready;
  assign retire    = (state_reg == DONE) & bus.out_ready;
  assign acc_write = retire & acc_op_reg;
  assign acc_wdata = (ACC_SATURATE && cout_reg) ? {WIDTH{1'b1}} : sum_reg;

  // Clear beats a retiring write; acc_next is also the forwarded B for in_acc.
  always_comb begin
    acc_next = acc_reg;
    ovf_next = ovf_reg;
    if (acc_clr) begin
      acc_next = '0;
      ovf_next = 1'b0;
    end else if (acc_write) begin
      acc_next = acc_wdata;
      ovf_next = ovf_reg | cout_reg;
    end
  end

  assign b_eff = bus.in_acc ? acc_next : bus.in_b;

  bk_operand_pack u_pack (
    .a   (bus.in_a),
    .b   (b_eff),
    .bus (packed_bus)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SETTLE;
          cnt_next   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        if (retire) begin
          if (accept) begin
            state_next = SETTLE;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      adder_in_reg <= '0;
      acc_op_reg   <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      if (accept) begin
        adder_in_reg <= packed_bus;
        acc_op_reg   <= bus.in_acc;
      end
      if (capture) begin
        sum_reg  <= adder_out[WIDTH-1:0];
        cout_reg <= adder_out[WIDTH];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
  assign adder_in      = adder_in_reg;
  assign acc_q         = acc_reg;
  assign acc_ovf       = ovf_reg;

endmodule
